// File: rtl/seq110_pkg.sv
// Shared definitions for the "110" marker protocol: transmitter state encoding,
// the marker pattern and small helpers used by both sender and detector sides.
package seq110_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMark = 2'd1,
    StData = 2'd2,
    StGap  = 2'd3
  } tx_state_e;

  // Marker is sent MSB first: 1, 1, 0.
  localparam logic [2:0]  MARKER   = 3'b110;
  localparam int unsigned MARK_LEN = 3;

  // Marker bit transmitted at position pos (0 = first bit on the line).
  function automatic logic marker_bit(input logic [1:0] pos);
    logic b;
    case (pos)
      2'd0:    b = MARKER[2];
      2'd1:    b = MARKER[1];
      2'd2:    b = MARKER[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seq110_tx.sv
// Serial frame transmitter: accepts a parallel word over valid/ready, then sends
// the 110 marker, the payload MSB-first and GAP_BITS guard zeros on y.
module seq110_tx
  import seq110_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              y,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CntW = $clog2(max3(MARK_LEN, DATA_W, GAP_BITS) + 1);
  localparam logic [CntW-1:0] MarkLast = CntW'(MARK_LEN - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_e         state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              y_q;
  logic              busy_q;
  logic              frame_done_q;

  logic [CntW-1:0]   cnt_inc;
  logic [DATA_W-1:0] shreg_shl;

  // Helper values shared by the state transitions below.
  always_comb begin
    cnt_inc   = cnt_q + 1'b1;
    shreg_shl = shreg_q << 1;
  end

  // Frame FSM; y/busy/frame_done are registered as the values for the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      y_q          <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          frame_done_q <= 1'b0;
          if (din_valid) begin
            state_q <= StMark;
            cnt_q   <= '0;
            shreg_q <= din;
            y_q     <= marker_bit(2'd0);
            busy_q  <= 1'b1;
          end else begin
            y_q    <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        StMark: begin
          if (cnt_q == MarkLast) begin
            state_q      <= StData;
            cnt_q        <= '0;
            y_q          <= shreg_q[DATA_W-1];
            frame_done_q <= (DATA_W == 1);
          end else begin
            cnt_q <= cnt_inc;
            y_q   <= marker_bit(2'(cnt_inc));
          end
        end
        StData: begin
          shreg_q <= shreg_shl;
          if (cnt_q == DataLast) begin
            cnt_q        <= '0;
            y_q          <= 1'b0;
            frame_done_q <= 1'b0;
            if (GAP_BITS > 0) begin
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q        <= cnt_inc;
            y_q          <= shreg_shl[DATA_W-1];
            frame_done_q <= (cnt_inc == DataLast);
          end
        end
        StGap: begin
          y_q <= 1'b0;
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q      <= StIdle;
          cnt_q        <= '0;
          y_q          <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = (state_q == StIdle);
  assign y          = y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
